// File: rtl/traffic_phase_scheduler.sv
// Highway/country intersection phase sequencer with pedestrian walk phase.
// Outputs are Moore decodes of the registered state; no input-to-output path and no backpressure.
module traffic_phase_scheduler #(
    parameter int Y2R_DELAY       = 3,
    parameter int R2G_DELAY       = 2,
    parameter int HWY_MIN_GREEN   = 8,
    parameter int CNTRY_MAX_GREEN = 10,
    parameter int WALK_TIME       = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
    input  logic       ped_btn,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ST_HG   = 3'd0,
        ST_HY   = 3'd1,
        ST_AR1  = 3'd2,
        ST_CG   = 3'd3,
        ST_CY   = 3'd4,
        ST_AR2  = 3'd5,
        ST_WALK = 3'd6,
        ST_BAD  = 3'd7
    } state_e;

    localparam logic [1:0] LT_RED = 2'd0;
    localparam logic [1:0] LT_YEL = 2'd1;
    localparam logic [1:0] LT_GRN = 2'd2;

    // Timer value on the last cycle of each phase (duration minus one).
    localparam logic [3:0] Y2R_LAST   = 4'(Y2R_DELAY - 1);
    localparam logic [3:0] R2G_LAST   = 4'(R2G_DELAY - 1);
    localparam logic [3:0] HWY_LAST   = 4'(HWY_MIN_GREEN - 1);
    localparam logic [3:0] CNTRY_LAST = 4'(CNTRY_MAX_GREEN - 1);
    localparam logic [3:0] WALK_LAST  = 4'(WALK_TIME - 1);

    state_e     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic       ped_q, ped_d;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_HG;
            timer_q <= 4'd0;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ped_q   <= ped_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HG: begin
                if ((timer_q >= HWY_LAST) && (X || ped_q)) begin
                    state_d = ST_HY;
                end
            end
            ST_HY: begin
                if (timer_q == Y2R_LAST) begin
                    state_d = ST_AR1;
                end
            end
            ST_AR1: begin
                if (timer_q == R2G_LAST) begin
                    if (ped_q) begin
                        state_d = ST_WALK;
                    end else if (X) begin
                        state_d = ST_CG;
                    end else begin
                        state_d = ST_HG;
                    end
                end
            end
            ST_WALK: begin
                if (timer_q == WALK_LAST) begin
                    state_d = X ? ST_CG : ST_HG;
                end
            end
            ST_CG: begin
                if (!X || (timer_q == CNTRY_LAST)) begin
                    state_d = ST_CY;
                end
            end
            ST_CY: begin
                if (timer_q == Y2R_LAST) begin
                    state_d = ST_AR2;
                end
            end
            ST_AR2: begin
                if (timer_q == R2G_LAST) begin
                    state_d = ST_HG;
                end
            end
            default: begin
                state_d = ST_HG;
            end
        endcase
    end

    // Dwell timer restarts on every state change and saturates at 15.
    always_comb begin
        timer_d = 4'd0;
        if (state_d == state_q) begin
            timer_d = (timer_q == 4'hF) ? timer_q : (timer_q + 4'd1);
        end
    end

    // A press on the WALK-entry edge is absorbed by the walk being granted.
    always_comb begin
        ped_d = ped_q | ped_btn;
        if ((state_d == ST_WALK) && (state_q != ST_WALK)) begin
            ped_d = 1'b0;
        end
    end

    always_comb begin
        hwy   = LT_GRN;
        cntry = LT_RED;
        walk  = 1'b0;
        phase = 3'd0;
        case (state_q)
            ST_HG: begin
                hwy   = LT_GRN;
                cntry = LT_RED;
                phase = 3'd0;
            end
            ST_HY: begin
                hwy   = LT_YEL;
                cntry = LT_RED;
                phase = 3'd1;
            end
            ST_AR1: begin
                hwy   = LT_RED;
                cntry = LT_RED;
                phase = 3'd2;
            end
            ST_CG: begin
                hwy   = LT_RED;
                cntry = LT_GRN;
                phase = 3'd3;
            end
            ST_CY: begin
                hwy   = LT_RED;
                cntry = LT_YEL;
                phase = 3'd4;
            end
            ST_AR2: begin
                hwy   = LT_RED;
                cntry = LT_RED;
                phase = 3'd5;
            end
            ST_WALK: begin
                hwy   = LT_RED;
                cntry = LT_RED;
                walk  = 1'b1;
                phase = 3'd6;
            end
            default: begin
                hwy   = LT_GRN;
                cntry = LT_RED;
                walk  = 1'b0;
                phase = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scenario bench: expected per-cycle light/phase words are queued before each run and popped as the DUT is sampled.
module tb_traffic_phase_scheduler;

    localparam int HG = 0, HY = 1, AR1 = 2, CG = 3, CY = 4, AR2 = 5, WK = 6;

    logic       clock;
    logic       clear;
    logic       X;
    logic       ped_btn;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       walk;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    traffic_phase_scheduler dut (
        .clock  (clock),
        .clear  (clear),
        .X      (X),
        .ped_btn(ped_btn),
        .hwy    (hwy),
        .cntry  (cntry),
        .walk   (walk),
        .phase  (phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected word {phase[2:0], hwy[1:0], cntry[1:0], walk} from the phase table.
    function automatic logic [7:0] word_of(input int ph);
        logic [1:0] h, c;
        logic       w;
        h = 2'd0; c = 2'd0; w = 1'b0;
        case (ph)
            HG:  begin h = 2'd2; c = 2'd0; end
            HY:  begin h = 2'd1; c = 2'd0; end
            CG:  begin h = 2'd0; c = 2'd2; end
            CY:  begin h = 2'd0; c = 2'd1; end
            WK:  begin w = 1'b1; end
            default: begin end
        endcase
        return {3'(ph), h, c, w};
    endfunction

    task automatic push_seg(input int ph, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(word_of(ph));
    endtask

    task automatic do_reset();
        clear   = 1'b1;
        X       = 1'b0;
        ped_btn = 1'b0;
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    // Runs cycles 0..n-1 after reset release, comparing one queued word per cycle.
    task automatic run(input string name, input int n, input bit x0, input int x_off,
                       input int ped_a, input int ped_b, input int clr_c);
        logic [7:0] got, want;
        for (int c = 0; c < n; c++) begin
            X       = x0 && ((x_off < 0) || (c < x_off));
            ped_btn = (c == ped_a) || (c == ped_b);
            clear   = (c == clr_c);
            @(negedge clock);
            got = {phase, hwy, cntry, walk};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s cycle %0d: no expected entry, got %h", name, c, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got phase=%0d hwy=%0d cntry=%0d walk=%0d, want phase=%0d hwy=%0d cntry=%0d walk=%0d",
                             name, c, got[7:5], got[4:3], got[2:1], got[0],
                             want[7:5], want[4:3], want[2:1], want[0]);
                end
            end
            @(posedge clock);
            #1;
        end
        X       = 1'b0;
        ped_btn = 1'b0;
        clear   = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftover: got %0d unconsumed entries, want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [7:0] got;
        // Walk into country yellow, then hold clear for three edges.
        do_reset();
        X = 1'b1;
        repeat (24) @(posedge clock);
        #1;
        clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            got = {phase, hwy, cntry, walk};
            checks++;
            if (i > 0 && got !== word_of(HG)) begin
                errors++;
                $display("FAIL reset_hold %0d: got %h, want %h", i, got, word_of(HG));
            end else if (i == 0 && got !== word_of(CY)) begin
                errors++;
                $display("FAIL reset_pre: got %h, want %h", got, word_of(CY));
            end
            @(posedge clock);
            #1;
        end
        clear = 1'b0;
        X     = 1'b0;
    endtask

    task automatic test_idle();
        do_reset();
        push_seg(HG, 60);
        run("idle", 60, 1'b0, -1, -1, -1, -1);
    endtask

    task automatic test_country_timeout();
        do_reset();
        push_seg(HG, 8); push_seg(HY, 3); push_seg(AR1, 2); push_seg(CG, 10);
        push_seg(CY, 3); push_seg(AR2, 2); push_seg(HG, 3);
        run("cntry_timeout", 31, 1'b1, -1, -1, -1, -1);
    endtask

    task automatic test_country_release();
        do_reset();
        push_seg(HG, 8); push_seg(HY, 3); push_seg(AR1, 2); push_seg(CG, 5);
        push_seg(CY, 3); push_seg(AR2, 2); push_seg(HG, 10);
        run("cntry_release", 33, 1'b1, 17, -1, -1, -1);
    endtask

    task automatic test_ped();
        do_reset();
        push_seg(HG, 8); push_seg(HY, 3); push_seg(AR1, 2); push_seg(WK, 4);
        push_seg(HG, 13);
        run("ped", 30, 1'b0, -1, 2, -1, -1);
    endtask

    task automatic test_ped_on_entry();
        do_reset();
        push_seg(HG, 8); push_seg(HY, 3); push_seg(AR1, 2); push_seg(WK, 4);
        push_seg(HG, 13);
        run("ped_on_entry", 30, 1'b0, -1, 2, 12, -1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_seg(HG, 8); push_seg(HY, 3); push_seg(AR1, 2); push_seg(CG, 10);
        push_seg(CY, 3); push_seg(AR2, 2); push_seg(HG, 8); push_seg(HY, 3);
        push_seg(AR1, 2); push_seg(WK, 4); push_seg(CG, 3);
        run("ped_in_cg", 48, 1'b1, -1, 15, -1, -1);
    endtask

    task automatic test_clear_mid();
        do_reset();
        push_seg(HG, 8); push_seg(HY, 3); push_seg(AR1, 2); push_seg(CG, 3);
        push_seg(HG, 14);
        run("clear_mid", 30, 1'b1, 16, 14, -1, 15);
    endtask

    initial begin
        clear   = 1'b1;
        X       = 1'b0;
        ped_btn = 1'b0;
        test_reset();
        test_idle();
        test_country_timeout();
        test_country_release();
        test_ped();
        test_ped_on_entry();
        test_back_to_back();
        test_clear_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
